// File: rtl/ral_regs_pkg.sv
// Shared register-map constants, reset values and decode types for the RAL register block.
package ral_regs_pkg;

  // Word-aligned byte addresses of the mapped registers
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] ADDR_CFG    = 32'h0000_0004;
  localparam logic [31:0] ADDR_DATA   = 32'h0000_0008;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_000C;
  localparam logic [31:0] ADDR_ID     = 32'h0000_0010;

  // Reset values of the read/write registers
  localparam logic [31:0] RST_CTRL = 32'h0000_0000;
  localparam logic [31:0] RST_CFG  = 32'h0000_0000;
  localparam logic [31:0] RST_DATA = 32'h0000_0000;

  // Defaults for the top-level parameters
  localparam logic [31:0] CFG_MASK_DEFAULT = 32'h0000_FFFF;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5241_4C01;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_CFG,
    SEL_DATA,
    SEL_STATUS,
    SEL_ID,
    SEL_NONE
  } reg_sel_e;

  // Only writes that land in a read/write register are accepted and counted
  function automatic logic is_rw(reg_sel_e sel);
    return (sel == SEL_CTRL) || (sel == SEL_CFG) || (sel == SEL_DATA);
  endfunction

endpackage

// File: rtl/modport_reg_block_if.sv
// Single-cycle write / registered-read register bus.
interface modport_reg_block_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/modport_reg_block.sv
// Memory-mapped register block: CTRL/CFG/DATA storage, accepted-write counter, constant ID,
// and a registered read port.
module modport_reg_block
  import ral_regs_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(ID_VALUE_DEFAULT),
  parameter logic [DATA_W-1:0] CFG_MASK = DATA_W'(CFG_MASK_DEFAULT)
) (
  input logic                clk,
  input logic                reset,
  modport_reg_block_if.slave bus
);

  reg_sel_e          sel;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] cfg_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       wr_cnt_q;
  logic [DATA_W-1:0] rdata_q;

  // Full-address compare: misaligned and out-of-range addresses fall through to SEL_NONE
  always_comb begin
    sel = SEL_NONE;
    case (bus.addr)
      ADDR_W'(ADDR_CTRL):   sel = SEL_CTRL;
      ADDR_W'(ADDR_CFG):    sel = SEL_CFG;
      ADDR_W'(ADDR_DATA):   sel = SEL_DATA;
      ADDR_W'(ADDR_STATUS): sel = SEL_STATUS;
      ADDR_W'(ADDR_ID):     sel = SEL_ID;
      default:              sel = SEL_NONE;
    endcase
  end

  // Read mux over pre-edge register contents; unmapped reads return zero
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_CTRL:   rd_val = ctrl_q;
      SEL_CFG:    rd_val = cfg_q;
      SEL_DATA:   rd_val = data_q;
      SEL_STATUS: rd_val = DATA_W'(wr_cnt_q);
      SEL_ID:     rd_val = ID_VALUE;
      default:    rd_val = '0;
    endcase
  end

  // Register storage and write counter; reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= DATA_W'(RST_CTRL);
      cfg_q    <= DATA_W'(RST_CFG);
      data_q   <= DATA_W'(RST_DATA);
      wr_cnt_q <= '0;
    end else if (bus.wr_en) begin
      case (sel)
        SEL_CTRL: ctrl_q <= bus.wdata;
        SEL_CFG:  cfg_q  <= bus.wdata & CFG_MASK;
        SEL_DATA: data_q <= bus.wdata;
        default:  ;
      endcase
      if (is_rw(sel)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  // Registered read data; holds its value across write cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (!bus.wr_en) begin
      rdata_q <= rd_val;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_modport_reg_block.sv
// Directed bench for modport_reg_block: reads push expected data to a scoreboard queue, which is
// popped and checked once the registered read data appears.
module tb_modport_reg_block;
  import ral_regs_pkg::*;

  localparam logic [31:0] ID_EXP = 32'h5241_4C01;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  modport_reg_block_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  modport_reg_block #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .ID_VALUE(32'h5241_4C01),
    .CFG_MASK(32'h0000_FFFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wr_en = 1'b1;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  // Issue a read, queue the expectation, and check it against rdata after the capturing edge
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    bus.addr  = a;
    bus.wr_en = 1'b0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, bus.rdata, 32'hxxxx_xxxx);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bus.rdata, e);
    end
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.addr  = '0;
    bus.wr_en = 1'b0;
    bus.wdata = '0;
    pulse_reset();
    check("rst_rdata", bus.rdata, 32'h0);

    // Reset values
    do_read(ADDR_CTRL,   32'h0, "rst_ctrl");
    do_read(ADDR_CFG,    32'h0, "rst_cfg");
    do_read(ADDR_DATA,   32'h0, "rst_data");
    do_read(ADDR_STATUS, 32'h0, "rst_status");
    do_read(ADDR_ID,     ID_EXP, "rst_id");

    // CTRL write then read-back next cycle; counter ticks
    do_write(ADDR_CTRL, 32'hDEAD_BEEF);
    do_read(ADDR_CTRL,   32'hDEAD_BEEF, "ctrl_wr");
    do_read(ADDR_STATUS, 32'h1, "status_1");

    // rdata must hold across a write cycle
    do_write(ADDR_DATA, 32'h1111_2222);
    check("hold_on_write", bus.rdata, 32'h1);
    do_read(ADDR_DATA,   32'h1111_2222, "data_wr");
    do_read(ADDR_STATUS, 32'h2, "status_2");

    // CFG masking
    do_write(ADDR_CFG, 32'hFFFF_FFFF);
    do_read(ADDR_CFG,    32'h0000_FFFF, "cfg_mask");
    do_read(ADDR_STATUS, 32'h3, "status_3");

    // Read-only registers ignore writes and do not count
    do_write(ADDR_STATUS, 32'h0000_1234);
    do_write(ADDR_ID, 32'h0);
    do_read(ADDR_STATUS, 32'h3, "status_ro");
    do_read(ADDR_ID,     ID_EXP, "id_ro");

    // Unmapped reads return zero; unmapped / misaligned writes are dropped
    do_read(32'h0000_0014, 32'h0, "unmap_rd_14");
    do_read(ADDR_ID,       ID_EXP, "id_again");
    do_read(32'h0000_0002, 32'h0, "unmap_rd_02");
    do_read(ADDR_CTRL,     32'hDEAD_BEEF, "ctrl_again");
    do_read(32'hFFFF_FFF0, 32'h0, "unmap_rd_hi");
    do_write(32'h0000_0014, 32'h0000_0055);
    do_write(32'h0000_0001, 32'h0000_0077);
    do_read(ADDR_CTRL,   32'hDEAD_BEEF, "ctrl_after_unmap");
    do_read(ADDR_CFG,    32'h0000_FFFF, "cfg_after_unmap");
    do_read(ADDR_DATA,   32'h1111_2222, "data_after_unmap");
    do_read(ADDR_STATUS, 32'h3, "status_after_unmap");

    // Counter wrap: 0x10001 accepted writes from a fresh reset leaves STATUS at 1
    pulse_reset();
    check("rst2_rdata", bus.rdata, 32'h0);
    for (int i = 0; i < 32'h0001_0001; i++) begin
      do_write(ADDR_DATA, 32'(i));
    end
    do_read(ADDR_STATUS, 32'h1, "status_wrap");
    do_read(ADDR_DATA,   32'h0001_0000, "data_last");

    // Reset coincident with a write: the write is lost and everything clears
    bus.addr  = ADDR_DATA;
    bus.wdata = 32'hAAAA_5555;
    bus.wr_en = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    check("rst_mid_rdata", bus.rdata, 32'h0);
    do_read(ADDR_CTRL,   32'h0, "rst_mid_ctrl");
    do_read(ADDR_CFG,    32'h0, "rst_mid_cfg");
    do_read(ADDR_DATA,   32'h0, "rst_mid_data");
    do_read(ADDR_STATUS, 32'h0, "rst_mid_status");
    do_read(ADDR_ID,     ID_EXP, "rst_mid_id");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
